braille_ascii_encoder: RTL and testbench
========================================

# braille_ascii_encoder

Braille-keyboard-to-ASCII encoder: the reverse path of the ASCII-to-Braille display decoder. Six dot keys are pressed together as a chord. The block samples them, debounces the release, and translates the accumulated chord to an 8-bit ASCII code. Codes are queued in a small show-ahead FIFO with a valid/ready handshake toward the downstream consumer (UART, display or host logic).

## Interface
- DEBOUNCE_CYCLES, 4: consecutive all-released synchronized samples needed to end a chord; legal range ≥1.
- FIFO_DEPTH, 4: output queue entries; must be a power of two ≥2.
- clk  input  1  rising-edge system clock.
- rst  input  1  reset, asynchronous, active-high.
- dot  input  6  raw dot keys, active-high; dot[0]=dot 1 … dot[5]=dot 6; asynchronous to clk.
- ascii  output  8  head-of-queue ASCII code; 0x00 when queue empty.
- valid  output  1  queue non-empty; ascii is meaningful.
- ready  input  1  consumer accepts; pop on valid && ready.
- overflow  output  1  one-cycle pulse when a committed character is dropped because the queue is full.
- busy  output  1  chord capture in progress (state ≠ IDLE).

## Operation
- dot passes through a two-flop synchronizer; only the second stage (dot_s) is used below.
- FSM states:
  - IDLE → PRESS when dot_s ≠ 0. On entry: chord ← dot_s, zero counter ← 0.
  - PRESS: while dot_s ≠ 0: chord ← chord | dot_s, counter ← 0.
  - PRESS: while dot_s == 0: counter increments. When counter == DEBOUNCE_CYCLES−1 and dot_s == 0 → COMMIT.
  - PRESS: re-press before the threshold (bounce) resets the counter and keeps accumulating into the same chord.
  - COMMIT (one cycle): translate chord, push to FIFO, → IDLE.
- Translation follows standard six-dot English Braille letters a–z, output lowercase (0x61–0x7A). Examples:
  - a = dots 1 → 0x61
  - c = dots 1,4 → 0x63
  - k = dots 1,3 → 0x6B
  - z = dots 1,3,5,6 → 0x7A
- Any chord not in the table → 0x3F ('?').
- Push when full: character discarded, overflow pulses in the COMMIT cycle, FIFO contents unchanged.
- Push and pop in the same cycle while full: the pop frees the slot, the push is accepted and overflow stays 0.
- Push and pop in the same cycle while empty: not possible, because valid is registered from FIFO occupancy.
- Pointers are log2(FIFO_DEPTH) bits and wrap modulo FIFO_DEPTH. Occupancy count is log2(FIFO_DEPTH)+1 bits.
- Reset (any time, including mid-chord or mid-handshake):
  - state IDLE, chord 0, counter 0, FIFO empty, digit mode 0, synchronizer 0.
  - ascii = 0x00, valid = 0, overflow = 0, busy = 0.
  - A partially captured chord is never emitted.

## Timing
- Edge 0 is the first clock edge that samples raw dot == 0 at the end of a chord.
  - Edge 1: dot_s = 0.
  - Edge DEBOUNCE_CYCLES+1: enter COMMIT.
  - Edge DEBOUNCE_CYCLES+2: FIFO write.
  - With an empty queue, valid is high from edge DEBOUNCE_CYCLES+2 onward. Total latency is DEBOUNCE_CYCLES+2 clocks.
- Press detection: busy rises 2 clocks after raw dot first goes non-zero.
- ascii/valid change only on clock edges. After a pop, the next entry (if any) is presented on the following cycle, so sustained throughput is 1 char/clock.
- ascii and valid hold steady while valid && !ready.

## Configuration
- BRAILLE_NUMBER_EN defined:
  - Chord dots 3,4,5,6 (6'b111100) is the number sign. It is consumed (nothing pushed) and sets digit mode.
  - In digit mode, letter chords a–i emit '1'–'9' (0x31–0x39) and j emits '0' (0x30). Digit mode persists across these chords.
  - Any other chord clears digit mode and translates normally. A repeated number sign keeps digit mode set.
- BRAILLE_NUMBER_EN undefined: chord 3,4,5,6 emits '#' (0x23) and no digit mode logic exists.

## Test plan
- Single letter (DEBOUNCE_CYCLES=4): dot=6'b000001 for 10 clocks, then 0, ready=1 → ascii=0x61 with valid high for exactly one cycle, 6 clocks after the release edge; busy low afterward.
- Staggered chord with bounce: dot=000001 → 001001 → 001000 → 0 for 2 clocks → 001000 → 0 → exactly one character, 0x63.
- Backpressure/overflow: ready=0, enter chords a, b, c, d, e → overflow pulses once on e. Then ready=1 → 0x61, 0x62, 0x63, 0x64 on consecutive cycles, then valid=0.
- Unmapped chord: dot=6'b100000 → 0x3F.
- Macro: chords 3456, a, b, k → with BRAILLE_NUMBER_EN: 0x31, 0x32, 0x6B; without it: 0x23, 0x61, 0x62, 0x6B.
- Reset mid-chord: assert rst while dot=000011 held, release rst, then dot=0 for 20 clocks → valid never rises, ascii=0x00.

Source files
------------

// File: rtl/braille_ascii_encoder.sv
// Six-dot Braille chord keyboard to ASCII encoder with a show-ahead output FIFO.
// Optional number-sign / digit mode is enabled by defining BRAILLE_NUMBER_EN.
module braille_ascii_encoder #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned FIFO_DEPTH      = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] dot,
  output logic [7:0] ascii,
  output logic       valid,
  input  logic       ready,
  output logic       overflow,
  output logic       busy
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);
  localparam logic [PtrW:0]   Depth  = (PtrW + 1)'(FIFO_DEPTH);
  localparam logic [5:0]      NumSign = 6'b111100;

  typedef enum logic [1:0] {StIdle, StPress, StCommit} state_e;

  state_e            state_q, state_d;
  logic [5:0]        dot_m_q, dot_s_q;
  logic [5:0]        chord_q, chord_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [PtrW-1:0]   wptr_q, wptr_d, rptr_q, rptr_d;
  logic [PtrW:0]     count_q, count_d;
  logic [7:0]        mem_q [FIFO_DEPTH];
  logic              push_req, push, pop, full;
  logic [7:0]        push_char;
`ifdef BRAILLE_NUMBER_EN
  logic              digit_q, digit_d;
`endif

  function automatic logic [7:0] letter(input logic [5:0] c);
    unique case (c)
      6'b000001: letter = 8'h61;  6'b000011: letter = 8'h62;
      6'b001001: letter = 8'h63;  6'b011001: letter = 8'h64;
      6'b010001: letter = 8'h65;  6'b001011: letter = 8'h66;
      6'b011011: letter = 8'h67;  6'b010011: letter = 8'h68;
      6'b001010: letter = 8'h69;  6'b011010: letter = 8'h6A;
      6'b000101: letter = 8'h6B;  6'b000111: letter = 8'h6C;
      6'b001101: letter = 8'h6D;  6'b011101: letter = 8'h6E;
      6'b010101: letter = 8'h6F;  6'b001111: letter = 8'h70;
      6'b011111: letter = 8'h71;  6'b010111: letter = 8'h72;
      6'b001110: letter = 8'h73;  6'b011110: letter = 8'h74;
      6'b100101: letter = 8'h75;  6'b100111: letter = 8'h76;
      6'b111010: letter = 8'h77;  6'b101101: letter = 8'h78;
      6'b111101: letter = 8'h79;  6'b110101: letter = 8'h7A;
      default:   letter = 8'h3F;
    endcase
  endfunction

  assign valid    = (count_q != '0);
  assign full     = (count_q == Depth);
  assign pop      = valid && ready;
  // A same-cycle pop frees the slot, so a full queue still accepts the push.
  assign push     = push_req && (!full || pop);
  assign overflow = push_req && full && !pop;
  assign ascii    = valid ? mem_q[rptr_q] : 8'h00;
  assign busy     = (state_q != StIdle);

  always_comb begin
    state_d   = state_q;
    chord_d   = chord_q;
    cnt_d     = cnt_q;
    push_req  = 1'b0;
    push_char = letter(chord_q);
`ifdef BRAILLE_NUMBER_EN
    digit_d   = digit_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (dot_s_q != '0) begin
          state_d = StPress;
          chord_d = dot_s_q;
          cnt_d   = '0;
        end
      end
      StPress: begin
        if (dot_s_q != '0) begin
          chord_d = chord_q | dot_s_q;
          cnt_d   = '0;
        end else if (cnt_q == CntMax) begin
          state_d = StCommit;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StCommit: begin
        state_d  = StIdle;
        chord_d  = '0;
        cnt_d    = '0;
        push_req = 1'b1;
`ifdef BRAILLE_NUMBER_EN
        if (chord_q == NumSign) begin
          push_req = 1'b0;
          digit_d  = 1'b1;
        end else if (digit_q && push_char >= 8'h61 && push_char <= 8'h6A) begin
          push_char = (push_char == 8'h6A) ? 8'h30 : push_char - 8'h30;
        end else begin
          digit_d = 1'b0;
        end
`else
        if (chord_q == NumSign) push_char = 8'h23;
`endif
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    wptr_d  = push ? wptr_q + 1'b1 : wptr_q;
    rptr_d  = pop ? rptr_q + 1'b1 : rptr_q;
    count_d = count_q;
    if (push && !pop) count_d = count_q + 1'b1;
    else if (pop && !push) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dot_m_q <= '0;
      dot_s_q <= '0;
      state_q <= StIdle;
      chord_q <= '0;
      cnt_q   <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
`ifdef BRAILLE_NUMBER_EN
      digit_q <= 1'b0;
`endif
    end else begin
      dot_m_q <= dot;
      dot_s_q <= dot_m_q;
      state_q <= state_d;
      chord_q <= chord_d;
      cnt_q   <= cnt_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
`ifdef BRAILLE_NUMBER_EN
      digit_q <= digit_d;
`endif
    end
  end

  // Storage needs no reset: ascii is masked while the queue is empty.
  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= push_char;
  end

endmodule

// File: tb/tb_braille_ascii_encoder.sv
// Directed, table-driven bench for braille_ascii_encoder (default parameters).
module tb_braille_ascii_encoder;

  localparam int Deb = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] dot;
  logic [7:0] ascii;
  logic       valid, ready, overflow, busy;

  braille_ascii_encoder #(.DEBOUNCE_CYCLES(Deb), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .dot(dot), .ascii(ascii), .valid(valid),
    .ready(ready), .overflow(overflow), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0] dots;
    logic [7:0] exp;
  } vec_t;

  vec_t       vecs[10];
  logic [7:0] got_q[$];
  int         got_cyc[$];
  int         cyc = 0;
  int         ovf_cnt = 0;
  int         valid_seen = 0;
  int         n_checks = 0;
  int         n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Pops and pulses are observed mid-cycle; inputs only change at posedge+2.
  always @(negedge clk) begin
    if (valid && ready) begin
      got_q.push_back(ascii);
      got_cyc.push_back(cyc);
    end
    if (overflow) ovf_cnt++;
    if (valid) valid_seen++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic chord(input logic [5:0] d, input int hold);
    dot = d;
    tick(hold);
    dot = '0;
    tick(Deb + 8);
  endtask

  logic [7:0] mexp[4];
  int         mn;

  initial begin
    vecs[0] = '{6'b000001, 8'h61};
    vecs[1] = '{6'b001001, 8'h63};
    vecs[2] = '{6'b000101, 8'h6B};
    vecs[3] = '{6'b110101, 8'h7A};
    vecs[4] = '{6'b111010, 8'h77};
    vecs[5] = '{6'b001010, 8'h69};
    vecs[6] = '{6'b011010, 8'h6A};
    vecs[7] = '{6'b100101, 8'h75};
    vecs[8] = '{6'b100000, 8'h3F};
    vecs[9] = '{6'b000010, 8'h3F};

    rst = 1'b1; dot = '0; ready = 1'b0;
    #1;
    check("rst_ascii", ascii, 8'h00);
    check("rst_valid", valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_overflow", overflow, 1'b0);
    tick(3);
    rst = 1'b0;
    tick(2);

    // Single letter with exact latency.
    ready = 1'b1;
    dot = 6'b000001;
    tick(10);
    check("busy_held", busy, 1'b1);
    dot = '0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk);
      #1;
      check($sformatf("lat_valid_e%0d", k), valid, (k == Deb + 2));
      if (k == Deb + 2) check("lat_ascii", ascii, 8'h61);
    end
    check("lat_busy_after", busy, 1'b0);
    tick(4);
    got_q.delete(); got_cyc.delete();

    // Staggered chord with a short release bounce.
    dot = 6'b000001; tick(3);
    dot = 6'b001001; tick(3);
    dot = 6'b001000; tick(3);
    dot = 6'b000000; tick(2);
    dot = 6'b001000; tick(3);
    dot = '0; tick(Deb + 8);
    check("bounce_count", got_q.size(), 1);
    check("bounce_char", (got_q.size() > 0) ? got_q[0] : 8'hxx, 8'h63);
    got_q.delete(); got_cyc.delete();

    for (int i = 0; i < 10; i++) begin
      chord(vecs[i].dots, 4);
      check($sformatf("vec%0d_count", i), got_q.size(), 1);
      check($sformatf("vec%0d_char", i), (got_q.size() > 0) ? got_q[0] : 8'hxx, vecs[i].exp);
      got_q.delete(); got_cyc.delete();
    end

    // Backpressure fills the queue; the fifth chord overflows.
    ready = 1'b0;
    ovf_cnt = 0;
    chord(6'b000001, 3);
    chord(6'b000011, 3);
    chord(6'b001001, 3);
    chord(6'b011001, 3);
    check("ovf_before_e", ovf_cnt, 0);
    chord(6'b010001, 3);
    check("ovf_on_e", ovf_cnt, 1);
    check("bp_valid", valid, 1'b1);
    check("bp_ascii", ascii, 8'h61);
    check("bp_popped", got_q.size(), 0);
    ready = 1'b1;
    tick(8);
    check("drain_count", got_q.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < got_q.size()) begin
        check($sformatf("drain%0d", i), got_q[i], 8'h61 + 8'(i));
        if (i > 0) check($sformatf("drain%0d_cyc", i), got_cyc[i] - got_cyc[i-1], 1);
      end
    end
    check("drain_valid", valid, 1'b0);
    check("drain_ascii", ascii, 8'h00);
    got_q.delete(); got_cyc.delete();

`ifdef BRAILLE_NUMBER_EN
    mexp[0] = 8'h31; mexp[1] = 8'h32; mexp[2] = 8'h6B; mexp[3] = 8'h00; mn = 3;
`else
    mexp[0] = 8'h23; mexp[1] = 8'h61; mexp[2] = 8'h62; mexp[3] = 8'h6B; mn = 4;
`endif
    chord(6'b111100, 4);
    chord(6'b000001, 4);
    chord(6'b000011, 4);
    chord(6'b000101, 4);
    check("macro_count", got_q.size(), mn);
    for (int i = 0; i < 4; i++) begin
      if (i < mn && i < got_q.size()) check($sformatf("macro%0d", i), got_q[i], mexp[i]);
    end
    got_q.delete(); got_cyc.delete();

    // Reset in the middle of a held chord.
    dot = 6'b000011;
    tick(6);
    check("mid_busy", busy, 1'b1);
    rst = 1'b1;
    #1;
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_valid", valid, 1'b0);
    tick(2);
    rst = 1'b0;
    dot = '0;
    valid_seen = 0;
    tick(20);
    check("mid_valid_seen", valid_seen, 0);
    check("mid_ascii", ascii, 8'h00);
    check("mid_busy_after", busy, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
